// File: rtl/rr_arb8_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rr_arb8_ctrl_pkg
//
// Shared arbiter definitions used by the round-robin arbiter, its interface
// and its one-hot decoder.
//
//   N_REQ        number of requesters sharing the downstream resource
//   IDX_W        width of a requester index (log2 of N_REQ)
//   arb_state_e  arbiter FSM encoding: ST_IDLE = 1'b0, ST_GRANT = 1'b1
//   idx_inc      modulo-N_REQ increment of a requester index
// -----------------------------------------------------------------------------
package rr_arb8_ctrl_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef logic [N_REQ-1:0] req_vec_t;
    typedef logic [IDX_W-1:0] req_idx_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // N_REQ is a power of two, so the natural wrap of an IDX_W-bit add is
    // exactly the modulo-N_REQ step the priority pointer needs (7 + 1 -> 0).
    function automatic req_idx_t idx_inc(input req_idx_t idx);
        return idx + req_idx_t'(1);
    endfunction

endpackage : rr_arb8_ctrl_pkg

// File: rtl/rr_arb8_ctrl_if.sv
// -----------------------------------------------------------------------------
// rr_arb8_ctrl_if
//
// Request/grant bundle between the requester side and the arbiter.
//
//   en         requester side -> arbiter  arbiter enable
//   req        requester side -> arbiter  request vector, bit i = requester i
//   gnt        arbiter -> requester side  one-hot grant, zero when not valid
//   gnt_idx    arbiter -> requester side  index of the current/last winner
//   gnt_valid  arbiter -> requester side  a grant is active this cycle
//
// Modports:
//   master  the requester side (drives en/req, observes the grant)
//   slave   the arbiter        (observes en/req, drives the grant)
// -----------------------------------------------------------------------------
import rr_arb8_ctrl_pkg::*;

interface rr_arb8_ctrl_if;

    logic     en;
    req_vec_t req;
    req_vec_t gnt;
    req_idx_t gnt_idx;
    logic     gnt_valid;

    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid
    );

endinterface : rr_arb8_ctrl_if

// File: rtl/rr_arb8_ctrl_dec.sv
// -----------------------------------------------------------------------------
// onehot_dec3to8
//
// Combinational 3-to-8 one-hot decoder with enable.
//
//   idx     input   3  index to decode
//   en      input   1  decoder enable
//   onehot  output  8  bit idx set when en=1, all zero when en=0
// -----------------------------------------------------------------------------
import rr_arb8_ctrl_pkg::*;

module onehot_dec3to8 (
    input  req_idx_t idx,
    input  logic     en,
    output req_vec_t onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule : onehot_dec3to8

// File: rtl/rr_arb8_ctrl.sv
// -----------------------------------------------------------------------------
// rr_arb8_ctrl
//
// 8-way round-robin arbiter sharing one downstream resource. One winner is
// granted at a time; the grant is held while the winner keeps requesting, up
// to MAX_HOLD consecutive cycles (0 = unlimited). On release the priority
// pointer moves just past the winner and one idle cycle separates grants.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles per winner (1..255, 0 = no limit)
//   CNT_W     width of the hold counter, must be able to hold MAX_HOLD
//
// Ports:
//   clk   input   1  system clock, rising edge
//   rst   input   1  synchronous active-high reset, overrides everything
//   bus   slave modport of rr_arb8_ctrl_if:
//           en, req                 (inputs)
//           gnt, gnt_idx, gnt_valid (outputs, all from registered state)
// -----------------------------------------------------------------------------
import rr_arb8_ctrl_pkg::*;

module rr_arb8_ctrl #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    rr_arb8_ctrl_if.slave       bus
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic             HOLD_EN  = (MAX_HOLD != 0);

    arb_state_e       state_q,    state_d;
    req_idx_t         ptr_q,      ptr_d;
    req_idx_t         gnt_idx_q,  gnt_idx_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    req_idx_t         winner;
    logic             winner_found;
    logic             limit_hit;
    logic             release_now;
    logic             gnt_valid;
    req_vec_t         gnt_vec;

    // Rotating priority search: visit ptr, ptr+1, ... wrapping modulo 8 and
    // take the first requester found. The 3-bit add supplies the wrap.
    always_comb begin
        req_idx_t cand;
        winner       = ptr_q;
        winner_found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr_q + req_idx_t'(k);
            if (!winner_found && bus.req[cand]) begin
                winner       = cand;
                winner_found = 1'b1;
            end
        end
    end

    // Hold limit only applies when MAX_HOLD is non-zero; with no limit the
    // counter simply saturates and never forces a release.
    assign limit_hit   = HOLD_EN && (hold_cnt_q == HOLD_LIM);
    assign release_now = !bus.req[gnt_idx_q] || !bus.en || limit_hit;

    // Next-state / output logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_idx_d  = gnt_idx_q;
        hold_cnt_d = hold_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                // winner_found is equivalent to req != 0.
                if (bus.en && winner_found) begin
                    gnt_idx_d  = winner;
                    hold_cnt_d = CNT_ONE;
                    state_d    = ST_GRANT;
                end
            end

            ST_GRANT: begin
                // Requests from other requesters are not looked at here;
                // they are only considered once back in IDLE, which also
                // gives the mandatory single idle cycle between grants.
                if (release_now) begin
                    ptr_d   = idx_inc(gnt_idx_q);
                    state_d = ST_IDLE;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            gnt_idx_q  <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_idx_q  <= gnt_idx_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // The valid flag is the FSM state itself, so the grant vector is decoded
    // purely from registers and cannot glitch with req.
    assign gnt_valid = (state_q == ST_GRANT);

    onehot_dec3to8 u_dec (
        .idx    (gnt_idx_q),
        .en     (gnt_valid),
        .onehot (gnt_vec)
    );

    assign bus.gnt       = gnt_vec;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = gnt_valid;

endmodule : rr_arb8_ctrl

// File: tb/tb_rr_arb8_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rr_arb8_ctrl
//
// Two arbiter instances: u_dut4 with MAX_HOLD=4 and u_dut0 with MAX_HOLD=0
// (unlimited). Directed vectors carry hand-computed expected grant state;
// each vector queues its expectation, tagged with the cycle it applies to,
// and an independent monitor pops and compares after each clock edge.
// -----------------------------------------------------------------------------
import rr_arb8_ctrl_pkg::*;

module tb_rr_arb8_ctrl;

    logic clk = 1'b0;
    logic rst4;
    logic rst0;

    always #5 clk = ~clk;

    rr_arb8_ctrl_if bus4 ();
    rr_arb8_ctrl_if bus0 ();

    rr_arb8_ctrl #(.MAX_HOLD(4), .CNT_W(8)) u_dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (bus4)
    );

    rr_arb8_ctrl #(.MAX_HOLD(0), .CNT_W(8)) u_dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (bus0)
    );

    typedef struct {
        int       cyc;
        bit       sel;   // 0 = u_dut4, 1 = u_dut0
        bit       v;
        req_idx_t idx;
        string    name;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_item(input exp_t e);
        logic     av;
        req_idx_t ai;
        req_vec_t ag;
        req_vec_t eg;
        av = e.sel ? bus0.gnt_valid : bus4.gnt_valid;
        ai = e.sel ? bus0.gnt_idx   : bus4.gnt_idx;
        ag = e.sel ? bus0.gnt       : bus4.gnt;
        eg = '0;
        if (e.v) eg[e.idx] = 1'b1;

        checks++;
        if (av !== e.v) begin
            errors++;
            $display("FAIL %s.valid cyc=%0d got=%b exp=%b", e.name, cyc, av, e.v);
        end
        checks++;
        if (ai !== e.idx) begin
            errors++;
            $display("FAIL %s.idx cyc=%0d got=%0d exp=%0d", e.name, cyc, ai, e.idx);
        end
        checks++;
        if (ag !== eg) begin
            errors++;
            $display("FAIL %s.gnt cyc=%0d got=%h exp=%h", e.name, cyc, ag, eg);
        end
    endtask

    // Monitor: after each edge, compare every expectation due this cycle.
    always @(posedge clk) begin
        exp_t e;
        #2;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc != cyc) begin
                checks++;
                errors++;
                $display("FAIL %s.stale got_cyc=%0d exp_cyc=%0d", e.name, cyc, e.cyc);
            end else begin
                check_item(e);
            end
        end
    end

    // Apply one vector to the selected DUT and queue the expected outputs
    // after the next clock edge.
    task automatic step(input bit sel, input bit r, input bit en,
                        input req_vec_t rq, input bit ev, input req_idx_t ei,
                        input string nm);
        exp_t e;
        if (sel) begin
            rst0 = r; bus0.en = en; bus0.req = rq;
        end else begin
            rst4 = r; bus4.en = en; bus4.req = rq;
        end
        e.cyc  = cyc + 1;
        e.sel  = sel;
        e.v    = ev;
        e.idx  = ei;
        e.name = nm;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst4 = 1'b1; bus4.en = 1'b0; bus4.req = '0;
        rst0 = 1'b1; bus0.en = 1'b0; bus0.req = '0;
        @(posedge clk);
        #1;

        // ---------------- MAX_HOLD = 4 instance ----------------
        step(0, 1, 1, 8'hFF, 0, 0, "rst_a");
        step(0, 1, 1, 8'hFF, 0, 0, "rst_b");
        step(0, 0, 1, 8'hFF, 1, 0, "first_gnt");
        repeat (3) step(0, 0, 1, 8'h81, 1, 0, "rr_hold0");
        step(0, 0, 1, 8'h81, 0, 0, "rr_limit_idle");
        repeat (4) step(0, 0, 1, 8'h81, 1, 7, "rr_idx7");
        step(0, 0, 1, 8'h81, 0, 7, "rr_idle2");
        step(0, 0, 1, 8'h81, 1, 0, "rr_back0");
        step(0, 0, 0, 8'h00, 0, 0, "en_drop");
        step(0, 0, 0, 8'hFF, 0, 0, "en_low_idle");
        step(0, 0, 1, 8'h28, 1, 3, "early_g3");
        step(0, 0, 1, 8'h28, 1, 3, "early_hold");
        step(0, 0, 1, 8'h20, 0, 3, "early_rel");
        step(0, 0, 1, 8'h28, 1, 5, "rot_g5");
        step(0, 0, 1, 8'h08, 0, 5, "rel5");
        step(0, 0, 1, 8'h28, 1, 3, "wrap_g3");
        step(0, 0, 1, 8'h40, 0, 3, "rel3");
        step(0, 0, 1, 8'h40, 1, 6, "g6");
        step(0, 0, 1, 8'h41, 1, 6, "g6_new_req_ignored");
        step(0, 0, 1, 8'h01, 0, 6, "rel6");
        step(0, 0, 1, 8'h41, 1, 0, "wrap_g0");
        step(0, 0, 1, 8'h04, 0, 0, "rel0");
        step(0, 0, 1, 8'h04, 1, 2, "g2");
        step(0, 0, 0, 8'h04, 0, 2, "en_mid_rel");
        step(0, 0, 0, 8'h04, 0, 2, "en_low_hold");
        step(0, 0, 0, 8'hFF, 0, 2, "en_low_ff");
        step(0, 0, 1, 8'h04, 1, 2, "g2_again");
        step(0, 1, 1, 8'h04, 0, 0, "rst_mid");
        step(0, 0, 1, 8'h81, 1, 0, "ptr_reset");
        step(0, 0, 1, 8'h00, 0, 0, "rel_req0");
        repeat (2) step(0, 0, 1, 8'h00, 0, 0, "idle_req0");
        repeat (4) step(0, 0, 1, 8'h01, 1, 0, "lim_g0");
        step(0, 0, 1, 8'h00, 0, 0, "lim_drop");
        step(0, 0, 1, 8'h03, 1, 1, "lim_next1");
        step(0, 0, 1, 8'h00, 0, 1, "end_rel");

        rst4 = 1'b0; bus4.en = 1'b0; bus4.req = '0;

        // ---------------- MAX_HOLD = 0 instance ----------------
        step(1, 1, 1, 8'h10, 0, 0, "u_rst");
        repeat (300) step(1, 0, 1, 8'h10, 1, 4, "u_hold");
        checks++;
        if (u_dut0.hold_cnt_q !== 8'hFF) begin
            errors++;
            $display("FAIL u_cnt_sat got=%h exp=ff", u_dut0.hold_cnt_q);
        end
        step(1, 0, 1, 8'h00, 0, 4, "u_rel");
        step(1, 0, 1, 8'h00, 0, 4, "u_idle");

        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d exp=0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rr_arb8_ctrl
